// File: rtl/regfile.sv
// ============================================================================
// regfile
// ----------------------------------------------------------------------------
// Integer register file for a single-issue RV32I core. Decode reads two
// operands combinationally; writeback writes one register per rising edge.
// x0 is hardwired to zero.
//
// Parameters
//   XLEN   : register width in bits
//   NREGS  : number of architectural registers (2..32)
//   BYPASS : 1 -> a read of the register being written this cycle returns wd
//            0 -> the read returns the stored value until after the edge
//
// Ports
//   clk  in   1     clock, all state updates on the rising edge
//   rst  in   1     synchronous active-high reset, clears every register
//   we   in   1     write enable
//   rs1  in   5     read address, port 1
//   rs2  in   5     read address, port 2
//   rd   in   5     write address
//   wd   in   XLEN  write data
//   rd1  out  XLEN  read data, port 1
//   rd2  out  XLEN  read data, port 2
//
// Interface contract: there is no handshake. Reads are pure combinational
// functions of (rs*, stored state, and the pending write when BYPASS=1);
// a write is committed on every rising edge where we=1, rst=0, rd!=0 and
// rd addresses an implemented register.
// ============================================================================
module regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    // Index width into the storage array.
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // A write only takes effect for a non-zero, implemented register and is
    // dropped entirely in a reset cycle.
    logic wr_en;

    always_comb begin
        wr_en = we && !rst && (rd != 5'd0) && (int'(rd) < NREGS);
    end

    // Next-state for the whole array: reset wins over a write.
    always_comb begin
        regs_d = regs_q;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_en) begin
            regs_d[rd[AW-1:0]] = wd;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // One read port. x0 and unimplemented addresses read zero; with BYPASS
    // the pending write is forwarded, which wr_en already suppresses during
    // reset so outputs never show a write that will be dropped.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] ra);
        logic [XLEN-1:0] val;
        val = '0;
        if (ra != 5'd0 && int'(ra) < NREGS) begin
            if (BYPASS != 0 && wr_en && ra == rd) begin
                val = wd;
            end else begin
                val = regs_q[ra[AW-1:0]];
            end
        end
        return val;
    endfunction

    always_comb begin
        rd1 = read_port(rs1);
        rd2 = read_port(rs2);
    end

endmodule

// File: tb/tb_regfile.sv
// ============================================================================
// tb_regfile
// ----------------------------------------------------------------------------
// Drives directed and random traffic into regfile. The driver computes the
// expected (rd1, rd2) pair from an array model and pushes it on exp_q; the
// monitor pops and compares on the falling edge, while inputs are stable.
// ============================================================================
module tb_regfile;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int BYPASS = 1;

    logic            clk;
    logic            rst;
    logic            we;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .BYPASS(BYPASS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we (we),
        .rs1(rs1),
        .rs2(rs2),
        .rd (rd),
        .wd (wd),
        .rd1(rd1),
        .rd2(rd2)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ scoreboard
    logic [2*XLEN-1:0] exp_q[$];
    string             name_q[$];
    logic              sample_req;
    int                total;
    int                bad;

    // Architectural model: a plain array of register values.
    logic [XLEN-1:0] model [32];

    function automatic logic [XLEN-1:0] model_read(input logic [4:0] ra,
                                                   input logic r, input logic w,
                                                   input logic [4:0] wa,
                                                   input logic [XLEN-1:0] d);
        if (ra == 5'd0) return '0;
        if (BYPASS != 0 && !r && w && wa != 5'd0 && wa == ra) return d;
        return model[ra];
    endfunction

    function automatic void model_write(input logic r, input logic w,
                                        input logic [4:0] wa,
                                        input logic [XLEN-1:0] d);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (w && wa != 5'd0) begin
            model[wa] = d;
        end
    endfunction

    // --------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (sample_req) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: actual=empty required=entry");
            end else begin
                logic [2*XLEN-1:0] e;
                string             nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                total++;
                if (rd1 !== e[2*XLEN-1:XLEN]) begin
                    bad++;
                    $display("FAIL %s.rd1: actual=%h required=%h", nm, rd1, e[2*XLEN-1:XLEN]);
                end
                total++;
                if (rd2 !== e[XLEN-1:0]) begin
                    bad++;
                    $display("FAIL %s.rd2: actual=%h required=%h", nm, rd2, e[XLEN-1:0]);
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver
    // Called just after a rising edge: applies one cycle of inputs, queues the
    // expected read data when chk=1, then commits the edge into the model.
    task automatic step(input logic r, input logic w, input logic [4:0] a_rd,
                        input logic [XLEN-1:0] d, input logic [4:0] a1,
                        input logic [4:0] a2, input logic chk, input string nm);
        rst = r;
        we  = w;
        rd  = a_rd;
        wd  = d;
        rs1 = a1;
        rs2 = a2;
        if (chk) begin
            exp_q.push_back({model_read(a1, r, w, a_rd, d), model_read(a2, r, w, a_rd, d)});
            name_q.push_back(nm);
        end
        sample_req = chk;
        @(posedge clk);
        model_write(r, w, a_rd, d);
        #1;
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        total      = 0;
        bad        = 0;
        sample_req = 1'b0;
        rst = 1'b1; we = 1'b0; rd = '0; wd = '0; rs1 = '0; rs2 = '0;
        for (int i = 0; i < 32; i++) model[i] = 'x;
        @(posedge clk);
        #1;

        // Reset cycle: outputs are undefined before it, so no check here.
        step(1, 0, 0, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 0, 5, 31, 1, "reset_read");
        step(0, 1, 5, 100, 0, 0, 1, "wr5");
        step(0, 0, 0, 0, 5, 5, 1, "read5");
        step(0, 1, 10, 200, 0, 0, 1, "wr10");
        step(0, 0, 0, 0, 10, 5, 1, "read10_5");
        step(0, 1, 0, 32'hDEADBEEF, 0, 0, 1, "wr_x0");
        step(0, 0, 0, 0, 0, 0, 1, "read_x0");
        step(0, 1, 7, 32'h1234, 7, 7, 1, "bypass7");
        step(0, 0, 0, 0, 7, 10, 1, "after7");
        step(1, 1, 5, 55, 5, 10, 1, "rst_prio");
        step(0, 0, 0, 0, 5, 10, 1, "post_rst");
        step(0, 0, 0, 0, 7, 31, 1, "post_rst_b");

        // Random traffic. Addresses are sometimes drawn from a small pool
        // and sometimes forced equal to rd to hit the forwarding path.
        for (int n = 0; n < 400; n++) begin
            logic            r_r;
            logic            r_w;
            logic [4:0]      r_rd;
            logic [4:0]      r_a1;
            logic [4:0]      r_a2;
            logic [XLEN-1:0] r_d;
            r_r  = ($urandom_range(0, 49) == 0);
            r_w  = ($urandom_range(0, 3) != 0);
            r_rd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r_d  = $urandom;
            r_a1 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
            r_a2 = ($urandom_range(0, 3) == 0) ? r_rd :
                   ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            step(r_r, r_w, r_rd, r_d, r_a1, r_a2, 1, "random");
        end

        // Drain: one idle cycle lets the monitor consume the last entry.
        step(0, 0, 0, 0, 0, 0, 0, "idle");
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d left required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
